// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port memory between instruction fetch (IF) and data memory (DM).
// Each access is serialised through IDLE -> ISSUE -> [WAIT] -> RESP, with a one-cycle
// ack to whichever port owns the transaction. DM normally wins arbitration. IF is forced
// through after STARVE_MAX consecutive DM grants that passed it over. Per-port wait
// counters feed the structural-stall statistics.

module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              reset,

    // Instruction-fetch port (read only)
    input  logic              if_req,
    input  logic [AW-1:0]     if_addr,
    output logic              if_ack,
    output logic [DW-1:0]     if_rdata,

    // Data-memory port
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [AW-1:0]     dm_addr,
    input  logic [DW-1:0]     dm_wdata,
    output logic              dm_ack,
    output logic [DW-1:0]     dm_rdata,

    // Pipeline control
    input  logic              halt,

    // Memory array side
    output logic              mem_en,
    output logic              mem_we,
    output logic [AW-3:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    input  logic [DW-1:0]     mem_rdata,

    // Status
    output logic              busy,
    output logic [CNT_W-1:0]  if_wait_cnt,
    output logic [CNT_W-1:0]  dm_wait_cnt
);

    // Width of the read-latency down-counter (always at least one bit).
    localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    // Width of the starvation counter, which must be able to hold STARVE_MAX.
    localparam int STV_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    localparam logic [LAT_W-1:0] LAT_LOAD   = LAT_W'(MEM_LAT - 1);
    localparam logic [STV_W-1:0] STARVE_TOP = STV_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

    // ------------------------------------------------------------------
    // State and bookkeeping registers
    // ------------------------------------------------------------------
    state_t             r_state;
    owner_t             r_owner;
    logic               r_is_write;
    logic [LAT_W-1:0]   r_lat_cnt;
    logic [STV_W-1:0]   r_starve_cnt;

    // Registered outputs
    logic               r_if_ack;
    logic [DW-1:0]      r_if_rdata;
    logic               r_dm_ack;
    logic [DW-1:0]      r_dm_rdata;
    logic               r_mem_en;
    logic               r_mem_we;
    logic [AW-3:0]      r_mem_addr;
    logic [DW-1:0]      r_mem_wdata;
    logic               r_busy;
    logic [CNT_W-1:0]   r_if_wait_cnt;
    logic [CNT_W-1:0]   r_dm_wait_cnt;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    state_t             w_state_nxt;
    logic               w_grant_if;
    logic               w_grant_dm;
    logic               w_grant_any;
    logic               w_ack_set;
    logic               w_capture;
    logic               w_if_elig;
    logic               w_starved;
    logic               w_if_served;
    logic               w_dm_served;
    logic               w_unused_addr_lsbs;

    // halt only stops IF from winning a new grant; an IF access already underway finishes.
    assign w_if_elig = if_req & ~halt;
    assign w_starved = (r_starve_cnt == STARVE_TOP);

    assign w_grant_any = w_grant_if | w_grant_dm;

    // A port is being served while it owns any non-IDLE state; otherwise a raised req is waiting.
    assign w_if_served = (r_state != S_IDLE) && (r_owner == OWN_IF);
    assign w_dm_served = (r_state != S_IDLE) && (r_owner == OWN_DM);

    // The memory is word addressed, so the byte-offset bits carry no information.
    assign w_unused_addr_lsbs = ^{if_addr[1:0], dm_addr[1:0]};

    // Next-state, grant and response-strobe decode.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        w_state_nxt = r_state;
        w_grant_if  = 1'b0;
        w_grant_dm  = 1'b0;
        w_ack_set   = 1'b0;
        w_capture   = 1'b0;

        case (r_state)
            S_IDLE: begin
                // DM wins unless IF is eligible and has been passed over STARVE_MAX times.
                if (dm_req && !(w_if_elig && w_starved)) begin
                    w_grant_dm = 1'b1;
                end else if (w_if_elig) begin
                    w_grant_if = 1'b1;
                end
                if (w_grant_dm || w_grant_if) begin
                    w_state_nxt = S_ISSUE;
                end
            end

            S_ISSUE: begin
                // A write is complete once its strobe has gone out; reads must wait out the latency.
                if (r_is_write) begin
                    w_state_nxt = S_RESP;
                    w_ack_set   = 1'b1;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end

            S_WAIT: begin
                // The last WAIT cycle is the one in which mem_rdata is valid.
                if (r_lat_cnt == '0) begin
                    w_state_nxt = S_RESP;
                    w_ack_set   = 1'b1;
                    w_capture   = 1'b1;
                end
            end

            S_RESP: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            r_state <= w_state_nxt;
        end
    end

    // Latch the transaction owner and direction at grant; both hold through RESP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner    <= OWN_IF;
            r_is_write <= 1'b0;
        end else if (w_grant_dm) begin
            r_owner    <= OWN_DM;
            r_is_write <= dm_we;
        end else if (w_grant_if) begin
            r_owner    <= OWN_IF;
            r_is_write <= 1'b0;
        end
    end

    // Read-latency down-counter, loaded on ISSUE and decremented through WAIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lat_cnt <= '0;
        end else if (r_state == S_ISSUE) begin
            r_lat_cnt <= LAT_LOAD;
        end else if ((r_state == S_WAIT) && (r_lat_cnt != '0)) begin
            r_lat_cnt <= r_lat_cnt - LAT_W'(1);
        end
    end

    // Starvation counter: counts DM grants that passed over an eligible IF; cleared when IF wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (w_grant_if) begin
            r_starve_cnt <= '0;
        end else if (w_grant_dm && w_if_elig && !w_starved) begin
            r_starve_cnt <= r_starve_cnt + STV_W'(1);
        end
    end

    // Memory command registers: strobes pulse for the ISSUE cycle only; address/data hold between grants.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_mem_en <= w_grant_any;
            r_mem_we <= w_grant_dm & dm_we;
            if (w_grant_dm) begin
                r_mem_addr <= dm_addr[AW-1:2];
                if (dm_we) begin
                    r_mem_wdata <= dm_wdata;
                end
            end else if (w_grant_if) begin
                r_mem_addr <= if_addr[AW-1:2];
            end
        end
    end

    // Response registers: one-cycle ack to the owner; read data holds until the next read for that port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_if_ack   <= 1'b0;
            r_dm_ack   <= 1'b0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
        end else begin
            r_if_ack <= w_ack_set && (r_owner == OWN_IF);
            r_dm_ack <= w_ack_set && (r_owner == OWN_DM);
            if (w_capture && (r_owner == OWN_IF)) begin
                r_if_rdata <= mem_rdata;
            end
            if (w_capture && (r_owner == OWN_DM)) begin
                r_dm_rdata <= mem_rdata;
            end
        end
    end

    // Busy flag, registered alongside the state so it equals (state != IDLE).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != S_IDLE);
        end
    end

    // Saturating per-port wait counters: a cycle counts when req is high and the port is not being served.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_if_wait_cnt <= '0;
            r_dm_wait_cnt <= '0;
        end else begin
            if (if_req && !w_if_served && (r_if_wait_cnt != '1)) begin
                r_if_wait_cnt <= r_if_wait_cnt + CNT_W'(1);
            end
            if (dm_req && !w_dm_served && (r_dm_wait_cnt != '1)) begin
                r_dm_wait_cnt <= r_dm_wait_cnt + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Output drive
    // ------------------------------------------------------------------
    assign if_ack      = r_if_ack;
    assign if_rdata    = r_if_rdata;
    assign dm_ack      = r_dm_ack;
    assign dm_rdata    = r_dm_rdata;
    assign mem_en      = r_mem_en;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign busy        = r_busy;
    assign if_wait_cnt = r_if_wait_cnt;
    assign dm_wait_cnt = r_dm_wait_cnt;

endmodule
